// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel, operation-code and image-dimension definitions
package img_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        OP_INVERT     = 2'b00,
        OP_THRESHOLD  = 2'b01,
        OP_BRIGHTNESS = 2'b10,
        OP_GRAYSCALE  = 2'b11
    } op_t;

    localparam int DEFAULT_IMG_WIDTH  = 512;
    localparam int DEFAULT_IMG_HEIGHT = 512;

    // Coordinate counters need at least one bit even for a 1-pixel dimension
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_frame_framer_if.sv
// rtl/pixel_frame_framer_if.sv - upstream pixel stream and tagged output stream of the framer
interface pixel_frame_framer_if import img_pkg::*; #(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) ();
    localparam int XW = coord_width(IMG_WIDTH);
    localparam int YW = coord_width(IMG_HEIGHT);

    logic          s_valid;
    logic          s_ready;
    pixel_t        s_pixel;
    logic          s_sof;
    logic          m_valid;
    logic          m_ready;
    pixel_t        m_pixel;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    op_t           m_operation_select;

    // master: the pixel source / processing stage; slave: the framer itself
    modport master (
        output s_valid, s_pixel, s_sof, m_ready,
        input  s_ready, m_valid, m_pixel, m_sof, m_eol, m_eof, m_x, m_y, m_operation_select
    );

    modport slave (
        input  s_valid, s_pixel, s_sof, m_ready,
        output s_ready, m_valid, m_pixel, m_sof, m_eol, m_eof, m_x, m_y, m_operation_select
    );

endinterface

// File: rtl/pixel_tag_fifo.sv
// rtl/pixel_tag_fifo.sv - power-of-two FIFO carrying a pixel plus its frame tags
module pixel_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             push;
    logic             pop;

    assign full     = (count == CW'(DEPTH));
    assign s_tready = !full;
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign pop      = m_tvalid && m_tready;
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign push     = s_tvalid && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_frame_framer.sv
// rtl/pixel_frame_framer.sv - tags pixels with frame position and op code; FRAME_CHECK_EN adds s_sof checking/resync
module pixel_frame_framer import img_pkg::*; #(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cfg_operation_select,
    pixel_frame_framer_if.slave  bus,
    output logic [15:0]          frame_count,
    output logic                 frame_err
);
    localparam int XW = coord_width(IMG_WIDTH);
    localparam int YW = coord_width(IMG_HEIGHT);
    localparam int PW = $bits(pixel_t) + 3 + XW + YW + 2;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    op_t           op_q;

    logic          fifo_ready;
    logic          accept;
    logic          restart;
    logic [XW-1:0] tag_x;
    logic [YW-1:0] tag_y;
    op_t           tag_op;
    logic          tag_eol;
    logic          tag_eof;
    logic [PW-1:0] push_data;
    logic [PW-1:0] pop_data;

    // Upstream sees no space while reset is held, whatever the FIFO reports
    assign bus.s_ready = fifo_ready && rst;
    assign accept      = bus.s_valid && bus.s_ready;

`ifdef FRAME_CHECK_EN
    assign restart = (state == IDLE) || bus.s_sof;
`else
    logic unused_sof;
    assign unused_sof = bus.s_sof;
    assign restart    = (state == IDLE);
    assign frame_err  = 1'b0;
`endif

    assign tag_x     = restart ? '0 : x;
    assign tag_y     = restart ? '0 : y;
    assign tag_op    = restart ? op_t'(cfg_operation_select) : op_q;
    assign tag_eol   = (tag_x == XW'(IMG_WIDTH - 1));
    assign tag_eof   = tag_eol && (tag_y == YW'(IMG_HEIGHT - 1));
    assign push_data = {tag_op, tag_y, tag_x, tag_eof, tag_eol, restart, bus.s_pixel};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            op_q        <= OP_INVERT;
            frame_count <= '0;
`ifdef FRAME_CHECK_EN
            frame_err   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q <= tag_op;
                if (tag_eof) begin
                    state       <= IDLE;
                    x           <= '0;
                    y           <= '0;
                    frame_count <= frame_count + 16'd1;
                end else if (tag_eol) begin
                    state <= ACTIVE;
                    x     <= '0;
                    y     <= tag_y + YW'(1);
                end else begin
                    state <= ACTIVE;
                    x     <= tag_x + XW'(1);
                    y     <= tag_y;
                end
            end
`ifdef FRAME_CHECK_EN
            // s_sof must be high exactly on the pixel that opens a frame
            frame_err <= accept && (bus.s_sof != (state == IDLE));
`endif
        end
    end

    pixel_tag_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (accept),
        .s_tready (fifo_ready),
        .s_tdata  (push_data),
        .m_tvalid (bus.m_valid),
        .m_tready (bus.m_ready),
        .m_tdata  (pop_data)
    );

    assign bus.m_pixel            = pop_data[23:0];
    assign bus.m_sof              = pop_data[24];
    assign bus.m_eol              = pop_data[25];
    assign bus.m_eof              = pop_data[26];
    assign bus.m_x                = pop_data[27 +: XW];
    assign bus.m_y                = pop_data[27 + XW +: YW];
    assign bus.m_operation_select = op_t'(pop_data[PW-1 -: 2]);

endmodule

// File: tb/tb_pixel_frame_framer.sv
// tb/tb_pixel_frame_framer.sv - directed-vector bench for pixel_frame_framer on a 4x2 frame
module tb_pixel_frame_framer;
    import img_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cfg = 2'b00;
    logic [15:0] frame_count;
    logic        frame_err;

    pixel_frame_framer_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    pixel_frame_framer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cfg_operation_select (cfg),
        .bus                  (bus),
        .frame_count          (frame_count),
        .frame_err            (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic        y;
        logic [1:0]  x;
        logic        eof;
        logic        eol;
        logic        sof;
        logic [23:0] pix;
    } rec_t;

    rec_t rx_q[$];
    int   acc_cnt = 0;
    int   err_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Inputs change at posedge+1, so the negedge view equals what the next edge sees
    always @(negedge clk) begin
        rec_t r;
        if (bus.m_valid && bus.m_ready) begin
            r = {bus.m_operation_select, bus.m_y, bus.m_x, bus.m_eof, bus.m_eol, bus.m_sof, bus.m_pixel};
            rx_q.push_back(r);
        end
        if (bus.s_valid && bus.s_ready) acc_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input logic [23:0] base, input bit first_sof);
        int   sent = 0;
        int   budget = 0;
        logic acc;
        bus.s_valid = 1'b1;
        while (sent < n && budget < 300) begin
            bus.s_pixel = 24'(base + sent);
            bus.s_sof   = first_sof && (sent == 0);
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            budget++;
            if (acc) sent++;
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        if (sent < n) chk("stream_timeout", 64'(sent), 64'(n));
    endtask

    task automatic drain(input int n);
        int b = 0;
        while (rx_q.size() < n && b < 200) begin
            cyc(1);
            b++;
        end
        cyc(2);
        chk("drain_count", 64'(rx_q.size()), 64'(n));
    endtask

    function automatic rec_t exp_rec(input logic [23:0] pix, input int pos, input logic [1:0] op);
        rec_t r;
        r.pix = pix;
        r.x   = 2'(pos % 4);
        r.y   = 1'(pos / 4);
        r.sof = (pos == 0);
        r.eol = (pos % 4 == 3);
        r.eof = (pos == 7);
        r.op  = op;
        return r;
    endfunction

    task automatic check_rx(input string tag, input int idx0, input logic [23:0] base,
                            input int pos0, input int n, input logic [1:0] op);
        for (int i = 0; i < n; i++) begin
            if (idx0 + i < rx_q.size())
                chk($sformatf("%s[%0d]", tag, i), 64'(rx_q[idx0 + i]), 64'(exp_rec(24'(base + i), pos0 + i, op)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc0;
        int err0;
        bus.s_valid = 1'b0;
        bus.s_pixel = '0;
        bus.s_sof   = 1'b0;
        bus.m_ready = 1'b0;
        cyc(2);

        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 64'(bus.s_ready), 64'd1);
        cyc(1);

        // 4x2 frame, pixels 1..8, sink always ready
        bus.m_ready = 1'b1;
        stream(8, 24'h000001, 1'b1);
        drain(8);
        check_rx("f1", 0, 24'h000001, 0, 8, 2'b00);
        chk("f1_frames", 64'(frame_count), 64'd1);
        rx_q.delete();

        // sink stalls 10 cycles: only D entries accepted, head held
        acc0 = acc_cnt;
        fork
            stream(8, 24'h000010, 1'b1);
            begin
                bus.m_ready = 1'b0;
                cyc(10);
                chk("stall_accepts", 64'(acc_cnt - acc0), 64'd4);
                chk("stall_s_ready", 64'(bus.s_ready), 64'd0);
                chk("stall_m_valid", 64'(bus.m_valid), 64'd1);
                chk("stall_hold", 64'(bus.m_pixel), 64'h10);
                chk("stall_no_out", 64'(rx_q.size()), 64'd0);
                bus.m_ready = 1'b1;
            end
        join
        drain(8);
        check_rx("f2", 0, 24'h000010, 0, 8, 2'b00);
        chk("f2_frames", 64'(frame_count), 64'd2);
        rx_q.delete();

        // op code change mid-frame applies only from the next frame
        cfg = 2'b00;
        stream(3, 24'h000020, 1'b1);
        cfg = 2'b11;
        stream(5, 24'h000023, 1'b0);
        stream(8, 24'h000030, 1'b1);
        drain(16);
        check_rx("op_old", 0, 24'h000020, 0, 8, 2'b00);
        check_rx("op_new", 8, 24'h000030, 0, 8, 2'b11);
        chk("op_frames", 64'(frame_count), 64'd4);
        chk("no_err_so_far", 64'(err_cnt), 64'd0);
        rx_q.delete();

        // reset after 3 buffered pixels
        bus.m_ready = 1'b0;
        stream(3, 24'h000040, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_m_bus", {bus.m_valid, bus.m_pixel, bus.m_sof, bus.m_eol, bus.m_eof,
                              bus.m_x, bus.m_y, bus.m_operation_select}, 64'd0);
        chk("mid_rst_frame_count", 64'(frame_count), 64'd0);
        chk("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("mid_rst_frame_err", 64'(frame_err), 64'd0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("post_rst_empty", 64'(rx_q.size()), 64'd0);
        bus.m_ready = 1'b1;
        stream(8, 24'h000050, 1'b1);
        drain(8);
        check_rx("post_rst", 0, 24'h000050, 0, 8, 2'b11);
        chk("post_rst_frames", 64'(frame_count), 64'd1);
        rx_q.delete();

        // fill FIFO, then release sink while upstream keeps pushing
        acc0 = acc_cnt;
        fork
            stream(8, 24'h000060, 1'b1);
            begin
                int b = 0;
                bus.m_ready = 1'b0;
                while (acc_cnt - acc0 < 4 && b < 50) begin
                    cyc(1);
                    b++;
                end
                cyc(1);
                chk("full_accepts", 64'(acc_cnt - acc0), 64'd4);
                chk("full_s_ready", 64'(bus.s_ready), 64'd0);
                bus.m_ready = 1'b1;
            end
        join
        drain(8);
        check_rx("full", 0, 24'h000060, 0, 8, 2'b11);
        chk("full_frames", 64'(frame_count), 64'd2);
        rx_q.delete();

        // s_sof asserted at (2,1)
        err0 = err_cnt;
        stream(6, 24'h000070, 1'b1);
        stream(1, 24'h000076, 1'b1);
`ifdef FRAME_CHECK_EN
        stream(7, 24'h000077, 1'b0);
        drain(14);
        check_rx("pre_resync", 0, 24'h000070, 0, 6, 2'b11);
        check_rx("resync", 6, 24'h000076, 0, 8, 2'b11);
        chk("resync_err_pulses", 64'(err_cnt - err0), 64'd1);
`else
        stream(1, 24'h000077, 1'b0);
        drain(8);
        check_rx("sof_ignored", 0, 24'h000070, 0, 8, 2'b11);
        chk("sof_err_pulses", 64'(err_cnt - err0), 64'd0);
`endif
        chk("last_frames", 64'(frame_count), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
